ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised instruction sequencer for the stack CPU: fetches instructions from program memory, decodes them into datapath fields (op_code, source/destination values and choices, stack push/pop), and resolves control flow itself (JMP/JZ/JNZ/CALL/RET/HALT). Compared with the existing control module, it adds:
- a ready/valid fetch interface;
- a ready/valid issue handshake to the datapath;
- an internal return-address stack of configurable depth;
- a pop count for two-stack-operand instructions;
- sticky halt and error states.

It sits between instruction memory and the ALU/stack datapath.

## Interface
Parameters:
- OPCODE_WIDTH, 4, opcode field width
- VALUE_WIDTH, 8, width of each operand value field
- PC_WIDTH, 8, program counter width
- RS_DEPTH, 4, return-stack entries (≥1)
- INSTR_WIDTH, OPCODE_WIDTH+3*(2+VALUE_WIDTH), instruction width (derived). Layout MSB→LSB: opcode, s1_choice, s1, s2_choice, s2, d_choice, d.

Ports:
- clk  in  1  clock. Single clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous and active-high.
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address (= pc)
- imem_valid  in  1  fetch data valid
- imem_data  in  INSTR_WIDTH  fetched instruction
- zero_flag  in  1  datapath zero flag
- exec_valid  out  1  datapath op issued
- exec_ready  in  1  datapath accepts op
- op_code  out  OPCODE_WIDTH  current opcode
- source1, source2, destination  out  VALUE_WIDTH  operand value fields
- source1_choice, source2_choice, destination_choice  out  2  operand selectors: 00 NONE, 01 IMM, 10 REG, 11 STACK
- push  out  1  destination is STACK, qualified by exec_valid
- pop_count  out  2  number of sources with STACK choice, qualified by exec_valid
- pc  out  PC_WIDTH  program counter
- halted  out  1  HALT executed
- error  out  1  return-stack overflow or underflow

## Operation
- Opcodes:
  - 0 NOP
  - 1 HALT
  - 2 JMP
  - 3 JZ
  - 4 JNZ
  - 5 CALL
  - 6 RET
  - 7..2^OPCODE_WIDTH-1: datapath ops
- States: FETCH, EXEC, HALT, ERROR.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid, latch imem_data into IR and go to EXEC.
- EXEC, datapath op:
  - exec_valid=1, with all fields held from IR.
  - On exec_ready: pc←pc+1, go to FETCH.
- EXEC, control op: resolved in a single cycle, exec_valid=0.
  - NOP: pc+1.
  - JMP: pc←source1[PC_WIDTH-1:0], zero-extended if VALUE_WIDTH<PC_WIDTH.
  - JZ: jump if zero_flag=1, else pc+1. zero_flag is sampled in the EXEC cycle.
  - JNZ: jump if zero_flag=0, else pc+1.
  - CALL: push pc+1 onto the return stack, then jump.
  - RET: pc←popped return address.
  - HALT: go to HALT; pc is not advanced.
- CALL with the return stack full, or RET with it empty: go to ERROR. Stack contents and pc are unchanged.
- HALT and ERROR are sticky until rst. In either state imem_req=0 and exec_valid=0.
- pc arithmetic wraps modulo 2^PC_WIDTH.
- push = exec_valid & (d_choice==STACK).
- pop_count = exec_valid ? (s1_choice==STACK)+(s2_choice==STACK) : 0.

## Timing
- Reset: state=FETCH, pc=0, IR=0, return stack empty. All outputs are 0, including imem_req, which is gated low while rst=1.
- imem_req=1 in the first cycle after rst deasserts.
- Minimum instruction latency:
  - datapath op: 2 cycles (FETCH with imem_valid, then EXEC with exec_ready);
  - control op: 2 cycles.
- Stalls: FETCH holds while imem_valid=0. EXEC holds while exec_ready=0. During a stall all outputs are stable and exec_valid stays high.
- Ignored inputs: imem_valid outside FETCH, and exec_ready outside a datapath-op EXEC.
- rst is asserted mid-fetch or mid-issue: abort, with no pc or stack update. The stalled exec_valid drops the cycle after rst is sampled.
- halted and error are registered; they rise in the cycle after the EXEC that caused them.
- The output fields reflect IR at all times and change only on an IR load.

## Structure
- Package ctrl_pkg:
  - opcode enum;
  - operand-choice enum (NONE/IMM/REG/STACK);
  - state enum;
  - localparam helpers for field offsets within the instruction.
- Sub-module return_stack: LIFO of RS_DEPTH×PC_WIDTH with push, pop, top, full and empty. It performs no write on push when full and no pointer move on pop when empty.

## Test plan
- **Reset then linear ops.** Reset, then supply ops 7,8,9 at addresses 0,1,2 with imem_valid one cycle after each request and exec_ready=1.
  - Expect imem_addr 0→1→2, one exec_valid pulse per op, pc=3.
- **Conditional branches.** JZ to 0x20 with zero_flag=1 → pc=0x20. JZ with zero_flag=0 at pc=5 → pc=6. JNZ with zero_flag=0 → jump taken.
- **CALL/RET.** CALL 0x40 at pc=0x10, then RET at 0x40 → pc=0x11.
  - With RS_DEPTH=4, a 5th nested CALL → error=1, and imem_req stays 0 until rst.
- **Stack operand decoding.** Datapath op with s1=s2=d=STACK → pop_count=2, push=1, asserted only while exec_valid=1.
  - Op with no STACK operands → pop_count=0, push=0.
- **Stalls.** Hold exec_ready=0 for 3 cycles → exec_valid and all fields stable for 4 cycles, pc advances once.
  - Stall imem_valid for 5 cycles → imem_addr held.
- **Reset and halt.** Assert rst during a stalled EXEC → outputs 0 next cycle, pc=0.
  - HALT at pc=7 → halted=1, pc=7, no further imem_req.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and instruction-field geometry for the stack-CPU instruction sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_HALT = 3'd1,
        OP_JMP  = 3'd2,
        OP_JZ   = 3'd3,
        OP_JNZ  = 3'd4,
        OP_CALL = 3'd5,
        OP_RET  = 3'd6
    } ctrl_op_e;

    localparam int OP_FIRST_DP = 7;

    typedef enum logic [1:0] {
        CH_NONE  = 2'd0,
        CH_IMM   = 2'd1,
        CH_REG   = 2'd2,
        CH_STACK = 2'd3
    } choice_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Operand slots counted from the LSB; each slot is {choice[1:0], value[vw-1:0]}.
    localparam int SLOT_D  = 0;
    localparam int SLOT_S2 = 1;
    localparam int SLOT_S1 = 2;
    localparam int SLOT_OP = 3;

    function automatic int value_lsb(input int slot, input int vw);
        return slot * (2 + vw);
    endfunction

    function automatic int choice_lsb(input int slot, input int vw);
        return slot * (2 + vw) + vw;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push when full and pop when empty leave the stack untouched.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_idx, top_idx;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign wr_idx  = AW'(cnt_q);
    assign top_idx = AW'(cnt_q - CW'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            cnt_d         = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer: fetches into IR, issues datapath ops over valid/ready,
// and resolves jumps, calls and returns locally with a return-address stack.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int PC_WIDTH     = 8,
    parameter int RS_DEPTH     = 4,
    parameter int INSTR_WIDTH  = OPCODE_WIDTH + 3 * (2 + VALUE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_valid,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    input  logic                    zero_flag,
    output logic                    exec_valid,
    input  logic                    exec_ready,
    output logic [OPCODE_WIDTH-1:0] op_code,
    output logic [VALUE_WIDTH-1:0]  source1,
    output logic [VALUE_WIDTH-1:0]  source2,
    output logic [VALUE_WIDTH-1:0]  destination,
    output logic [1:0]              source1_choice,
    output logic [1:0]              source2_choice,
    output logic [1:0]              destination_choice,
    output logic                    push,
    output logic [1:0]              pop_count,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted,
    output logic                    error,
    output state_e                  state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; once raised, valid and its payload hold until that edge.

    localparam int D_LSB  = value_lsb(SLOT_D, VALUE_WIDTH);
    localparam int DC_LSB = choice_lsb(SLOT_D, VALUE_WIDTH);
    localparam int S2_LSB = value_lsb(SLOT_S2, VALUE_WIDTH);
    localparam int S2C_LSB = choice_lsb(SLOT_S2, VALUE_WIDTH);
    localparam int S1_LSB = value_lsb(SLOT_S1, VALUE_WIDTH);
    localparam int S1C_LSB = choice_lsb(SLOT_S1, VALUE_WIDTH);
    localparam int OP_LSB = value_lsb(SLOT_OP, VALUE_WIDTH);

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]    pc_inc, jmp_tgt, rs_top;
    logic                   rs_push, rs_pop, rs_full, rs_empty, is_dp;

    assign op_code            = ir_q[OP_LSB  +: OPCODE_WIDTH];
    assign source1            = ir_q[S1_LSB  +: VALUE_WIDTH];
    assign source2            = ir_q[S2_LSB  +: VALUE_WIDTH];
    assign destination        = ir_q[D_LSB   +: VALUE_WIDTH];
    assign source1_choice     = ir_q[S1C_LSB +: 2];
    assign source2_choice     = ir_q[S2C_LSB +: 2];
    assign destination_choice = ir_q[DC_LSB  +: 2];

    assign is_dp   = (op_code >= OPCODE_WIDTH'(OP_FIRST_DP));
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign jmp_tgt = PC_WIDTH'(source1);

    return_stack #(.DEPTH(RS_DEPTH), .WIDTH(PC_WIDTH)) u_rs (
        .clk       (clk),
        .rst       (rst),
        .push      (rs_push),
        .pop       (rs_pop),
        .push_data (pc_inc),
        .top       (rs_top),
        .full      (rs_full),
        .empty     (rs_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rs_push = 1'b0;
        rs_pop  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_dp) begin
                    if (exec_ready) begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                    case (op_code)
                        OPCODE_WIDTH'(OP_HALT): begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        OPCODE_WIDTH'(OP_JMP): pc_d = jmp_tgt;
                        OPCODE_WIDTH'(OP_JZ):  if (zero_flag)  pc_d = jmp_tgt;
                        OPCODE_WIDTH'(OP_JNZ): if (!zero_flag) pc_d = jmp_tgt;
                        OPCODE_WIDTH'(OP_CALL): begin
                            if (rs_full) begin
                                state_d = ST_ERROR;
                                pc_d    = pc_q;
                            end else begin
                                rs_push = 1'b1;
                                pc_d    = jmp_tgt;
                            end
                        end
                        OPCODE_WIDTH'(OP_RET): begin
                            if (rs_empty) begin
                                state_d = ST_ERROR;
                                pc_d    = pc_q;
                            end else begin
                                rs_pop = 1'b1;
                                pc_d   = rs_top;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // imem_req is gated combinationally so nothing is requested while rst is held.
    assign imem_req   = (state_q == ST_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign exec_valid = (state_q == ST_EXEC) && is_dp;
    assign halted     = (state_q == ST_HALT);
    assign error      = (state_q == ST_ERROR);
    assign state_dbg  = state_q;
    assign push       = exec_valid && (destination_choice == CH_STACK);
    assign pop_count  = exec_valid ? (2'(source1_choice == CH_STACK) + 2'(source2_choice == CH_STACK))
                                   : 2'd0;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: instruction table with a modelled pc, issue scoreboard,
// and hand-written reset, stall, overflow and underflow sequences.
module tb_ctrl_sequencer;
    import ctrl_pkg::*;

    localparam logic [1:0] NONE = 2'd0, IMM = 2'd1, REG = 2'd2, STK = 2'd3;

    logic        clk, rst;
    logic        imem_req, imem_valid, zero_flag, exec_valid, exec_ready;
    logic [7:0]  imem_addr, source1, source2, destination, pc;
    logic [33:0] imem_data;
    logic [3:0]  op_code;
    logic [1:0]  source1_choice, source2_choice, destination_choice, pop_count;
    logic        push, halted, error;
    state_e      state_dbg;

    ctrl_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .zero_flag(zero_flag),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .op_code(op_code),
        .source1(source1), .source2(source2), .destination(destination),
        .source1_choice(source1_choice), .source2_choice(source2_choice),
        .destination_choice(destination_choice), .push(push), .pop_count(pop_count),
        .pc(pc), .halted(halted), .error(error), .state_dbg(state_dbg)
    );

    // Clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] op;
        logic [1:0] s1c;
        logic [7:0] s1;
        logic [1:0] s2c;
        logic [7:0] s2;
        logic [1:0] dc;
        logic [7:0] d;
        logic       zf;
        int         flat;
        int         rlat;
        logic [7:0] exp_pc;
        logic       exp_halt;
        logic       exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  cur_pc;
    logic [36:0] exp_q[$];
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] pack(input vec_t v);
        return {v.op, v.s1c, v.s1, v.s2c, v.s2, v.dc, v.d};
    endfunction

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1; imem_valid = 1'b0; imem_data = '0; exec_ready = 1'b1; zero_flag = 1'b0;
        tick();
        tick();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_flags", {halted, error, push, pop_count}, 0);
        chk("rst_fields", {op_code, source1_choice, source1, source2_choice, source2,
                           destination_choice, destination}, 0);
        chk("rst_state", state_dbg, ST_FETCH);
        rst = 1'b0;
        #1;
        chk("post_rst_req", imem_req, 1);
        cur_pc = 8'h00;
    endtask

    task automatic run_instr(input vec_t v);
        int          n;
        logic [33:0] instr;
        instr = pack(v);
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", imem_req, 1);
        chk("imem_addr", imem_addr, cur_pc);
        for (int i = 0; i < v.flat; i++) begin
            tick();
            chk("fetch_hold_addr", imem_addr, cur_pc);
            chk("fetch_hold_req", imem_req, 1);
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        zero_flag  = v.zf;
        if (v.op >= 4'd7)
            exp_q.push_back({instr, v.dc == STK, 2'(v.s1c == STK) + 2'(v.s2c == STK)});
        tick();
        imem_valid = 1'b0;
        imem_data  = 34'($urandom);
        if (v.op >= 4'd7) begin
            exec_ready = (v.rlat == 0);
            for (int i = 0; i < v.rlat; i++) begin
                chk("stall_valid", exec_valid, 1);
                chk("stall_fields", {op_code, source1_choice, source1, source2_choice, source2,
                                     destination_choice, destination}, instr);
                chk("stall_pc", pc, cur_pc);
                tick();
            end
            exec_ready = 1'b1;
            chk("issue_valid", exec_valid, 1);
        end else begin
            chk("ctrl_no_valid", exec_valid, 0);
        end
        tick();
        chk("next_pc", pc, v.exp_pc);
        chk("halted", halted, v.exp_halt);
        chk("error", error, v.exp_err);
        cur_pc = v.exp_pc;
    endtask

    // Scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (exec_valid && exec_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: actual=op %0h required=no issue", op_code);
                end else begin
                    chk("issue", {op_code, source1_choice, source1, source2_choice, source2,
                                  destination_choice, destination, push, pop_count},
                        exp_q.pop_front());
                end
            end else if (!exec_valid) begin
                chk("idle_push_pop", {push, pop_count}, 0);
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1'b1; imem_valid = 1'b0; imem_data = '0; exec_ready = 1'b1; zero_flag = 1'b0;
        cur_pc = '0;

        tbl[0]  = '{4'd7,  IMM, 8'h11, REG,  8'h03, REG,  8'h04, 1'b0, 1, 0, 8'h01, 1'b0, 1'b0};
        tbl[1]  = '{4'd8,  REG, 8'h02, IMM,  8'h05, REG,  8'h06, 1'b0, 1, 0, 8'h02, 1'b0, 1'b0};
        tbl[2]  = '{4'd9,  IMM, 8'h33, NONE, 8'h00, REG,  8'h01, 1'b0, 1, 0, 8'h03, 1'b0, 1'b0};
        tbl[3]  = '{4'd3,  IMM, 8'h20, NONE, 8'h00, NONE, 8'h00, 1'b1, 1, 0, 8'h20, 1'b0, 1'b0};
        tbl[4]  = '{4'd2,  IMM, 8'h05, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h05, 1'b0, 1'b0};
        tbl[5]  = '{4'd3,  IMM, 8'h30, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h06, 1'b0, 1'b0};
        tbl[6]  = '{4'd4,  IMM, 8'h10, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h10, 1'b0, 1'b0};
        tbl[7]  = '{4'd5,  IMM, 8'h40, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h40, 1'b0, 1'b0};
        tbl[8]  = '{4'd6,  NONE, 8'h00, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h11, 1'b0, 1'b0};
        tbl[9]  = '{4'd10, STK, 8'h00, STK,  8'h00, STK,  8'h00, 1'b0, 0, 3, 8'h12, 1'b0, 1'b0};
        tbl[10] = '{4'd15, IMM, 8'h07, REG,  8'h01, REG,  8'h02, 1'b0, 5, 0, 8'h13, 1'b0, 1'b0};
        tbl[11] = '{4'd0,  NONE, 8'h00, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h14, 1'b0, 1'b0};
        tbl[12] = '{4'd2,  IMM, 8'h07, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h07, 1'b0, 1'b0};
        tbl[13] = '{4'd1,  NONE, 8'h00, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h07, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 14; i++) run_instr(tbl[i]);
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'($urandom_range(0, 1));
            tick();
            chk("halt_no_req", imem_req, 0);
            chk("halt_sticky", {halted, pc}, {1'b1, 8'h07});
        end
        imem_valid = 1'b0;

        // Return-stack overflow on the fifth nested CALL.
        do_reset();
        v = '{4'd5, IMM, 8'h00, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            v.s1     = 8'h40 + 8'(i * 16);
            v.exp_pc = v.s1;
            v.flat   = $urandom_range(0, 2);
            run_instr(v);
        end
        v.s1      = 8'h80;
        v.exp_pc  = 8'h70;
        v.exp_err = 1'b1;
        run_instr(v);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_no_req", imem_req, 0);
            chk("err_sticky", {error, halted, pc}, {1'b1, 1'b0, 8'h70});
        end

        // RET with an empty return stack.
        do_reset();
        run_instr('{4'd6, NONE, 8'h00, NONE, 8'h00, NONE, 8'h00, 1'b0, 0, 0, 8'h00, 1'b0, 1'b1});

        // Reset while an issue is stalled.
        do_reset();
        imem_valid = 1'b1;
        imem_data  = {4'd12, STK, 8'h01, IMM, 8'h02, STK, 8'h03};
        exec_ready = 1'b0;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("abort_stalled_valid", exec_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_req_gated", imem_req, 0);
        chk("abort_valid_held", exec_valid, 1);
        tick();
        chk("abort_valid_drop", exec_valid, 0);
        chk("abort_pc", pc, 0);
        chk("abort_fields", {op_code, push, pop_count}, 0);
        rst = 1'b0;
        exec_ready = 1'b1;
        #1;
        chk("abort_refetch", {imem_req, imem_addr}, {1'b1, 8'h00});
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
